// File: rtl/ssd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ssd_pkg: segment patterns, converter states and decode helpers for  |
// | the seven-segment score display.             Revision: 1.0          |
// +--------------------------------------------------------------------+
package ssd_pkg;

  typedef logic [3:0] bcd_digit_t;

  // Patterns are {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low
  localparam logic [7:0] SEG_0     = 8'b0000_0011;
  localparam logic [7:0] SEG_1     = 8'b1001_1111;
  localparam logic [7:0] SEG_2     = 8'b0010_0101;
  localparam logic [7:0] SEG_3     = 8'b0000_1101;
  localparam logic [7:0] SEG_4     = 8'b1001_1001;
  localparam logic [7:0] SEG_5     = 8'b0100_1001;
  localparam logic [7:0] SEG_6     = 8'b0100_0001;
  localparam logic [7:0] SEG_7     = 8'b0001_1111;
  localparam logic [7:0] SEG_8     = 8'b0000_0001;
  localparam logic [7:0] SEG_9     = 8'b0000_1001;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [15:0] MAX_DISPLAY = 16'd9999;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic logic [7:0] seg_decode(input bcd_digit_t d);
    logic [7:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [15:0] add3_nibbles(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < 4; i++) begin
      if (s[i*4 +: 4] >= 4'd5)
        r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ssd_score_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ssd_score_ctrl_if: score handshake, enable and display pins.        |
// |                                              Revision: 1.0          |
// +--------------------------------------------------------------------+
interface ssd_score_ctrl_if;
  logic [15:0] score_in;
  logic        score_valid;
  logic        score_ready;
  logic        enable;
  logic [7:0]  an;
  logic [7:0]  seg;

  modport master (output score_in, score_valid, enable,
                  input  score_ready, an, seg);
  modport slave  (input  score_in, score_valid, enable,
                  output score_ready, an, seg);
endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bin2bcd_seq: valid/ready front end and 16-step double-dabble engine |
// | converting a saturated binary score to four BCD digits. Rev: 1.0    |
// +--------------------------------------------------------------------+
module bin2bcd_seq
  import ssd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bin,
  input  logic        valid,
  output logic        ready,
  output logic [15:0] bcd,
  output logic        bcd_update
);

  logic [1:0]  r_state;
  logic [15:0] r_bin;
  logic [15:0] r_scratch;
  logic [3:0]  r_bitcnt;
  logic [15:0] w_adj;

  assign w_adj      = add3_nibbles(r_scratch);
  assign ready      = (r_state == ST_IDLE);
  assign bcd        = r_scratch;
  assign bcd_update = (r_state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_bin     <= 16'd0;
      r_scratch <= 16'd0;
      r_bitcnt  <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (valid) begin
            r_bin     <= (bin > MAX_DISPLAY) ? MAX_DISPLAY : bin;
            r_scratch <= 16'd0;
            r_bitcnt  <= 4'd0;
            r_state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // Top bit of the 32-bit shift falls off; it is always 0 for inputs <= 9999
          {r_scratch, r_bin} <= {w_adj, r_bin} << 1;
          r_bitcnt           <= r_bitcnt + 4'd1;
          if (r_bitcnt == 4'd15)
            r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ssd_score_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ssd_score_ctrl: score-to-BCD conversion plus multiplexed 4-digit    |
// | seven-segment scan with optional leading-zero blanking. Rev: 1.0    |
// +--------------------------------------------------------------------+
module ssd_score_ctrl
  import ssd_pkg::*;
#(
  parameter int REFRESH_BITS = 20,
  parameter int BLANK_LZ     = 1
) (
  input  logic            board_clk,
  input  logic            Reset,
  ssd_score_ctrl_if.slave bus
);

  localparam logic [REFRESH_BITS-1:0] CNT_ONE = {{(REFRESH_BITS-1){1'b0}}, 1'b1};

  logic [REFRESH_BITS-1:0] r_cnt;
  logic [15:0]             r_disp_bcd;
  logic [7:0]              r_an;
  logic [7:0]              r_seg;
  logic [15:0]             w_bcd;
  logic                    w_bcd_update;
  logic [1:0]              w_sel;
  bcd_digit_t              w_digit;
  logic                    w_lz;
  logic                    w_blank;

  bin2bcd_seq u_conv (
    .clk        (board_clk),
    .rst        (Reset),
    .bin        (bus.score_in),
    .valid      (bus.score_valid),
    .ready      (bus.score_ready),
    .bcd        (w_bcd),
    .bcd_update (w_bcd_update)
  );

  assign w_sel   = r_cnt[REFRESH_BITS-1 -: 2];
  assign w_digit = r_disp_bcd[{w_sel, 2'b00} +: 4];

  // A digit is a leading zero when it and every more-significant digit are zero
  always_comb begin
    w_lz = 1'b0;
    case (w_sel)
      2'd1:    w_lz = (r_disp_bcd[15:4]  == 12'd0);
      2'd2:    w_lz = (r_disp_bcd[15:8]  == 8'd0);
      2'd3:    w_lz = (r_disp_bcd[15:12] == 4'd0);
      default: w_lz = 1'b0;
    endcase
  end

  assign w_blank = (BLANK_LZ != 0) && w_lz;

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      r_cnt      <= '0;
      r_disp_bcd <= 16'd0;
      r_an       <= 8'hFF;
      r_seg      <= SEG_BLANK;
    end else begin
      r_cnt <= r_cnt + CNT_ONE;
      if (w_bcd_update)
        r_disp_bcd <= w_bcd;
      if (bus.enable) begin
        r_an  <= ~(8'h01 << w_sel);
        r_seg <= w_blank ? SEG_BLANK : seg_decode(w_digit);
      end else begin
        r_an  <= 8'hFF;
        r_seg <= SEG_BLANK;
      end
    end
  end

  assign bus.an  = r_an;
  assign bus.seg = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_ssd_score_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ssd_score_ctrl: directed vectors against two instances, one with |
// | leading-zero blanking and one without.        Revision: 1.0         |
// +--------------------------------------------------------------------+
module tb_ssd_score_ctrl;

  localparam logic [7:0] S0 = 8'b0000_0011;
  localparam logic [7:0] S1 = 8'b1001_1111;
  localparam logic [7:0] S2 = 8'b0010_0101;
  localparam logic [7:0] S3 = 8'b0000_1101;
  localparam logic [7:0] S4 = 8'b1001_1001;
  localparam logic [7:0] S5 = 8'b0100_1001;
  localparam logic [7:0] S7 = 8'b0001_1111;
  localparam logic [7:0] S9 = 8'b0000_1001;
  localparam logic [7:0] BL = 8'hFF;

  typedef struct {
    logic [15:0] score;
    logic [31:0] lz;   // {An3,An2,An1,An0} seg with blanking
    logic [31:0] nz;   // same, without blanking
  } vec_t;

  logic        board_clk   = 1'b0;
  logic        Reset       = 1'b1;
  logic [15:0] score_in    = 16'd0;
  logic        score_valid = 1'b0;
  logic        enable      = 1'b0;
  int          total       = 0;
  int          bad         = 0;
  vec_t        vecs[9];

  ssd_score_ctrl_if bus_lz ();
  ssd_score_ctrl_if bus_nz ();

  assign bus_lz.score_in    = score_in;
  assign bus_lz.score_valid = score_valid;
  assign bus_lz.enable      = enable;
  assign bus_nz.score_in    = score_in;
  assign bus_nz.score_valid = score_valid;
  assign bus_nz.enable      = enable;

  ssd_score_ctrl #(.REFRESH_BITS(4), .BLANK_LZ(1)) dut_lz (
    .board_clk (board_clk),
    .Reset     (Reset),
    .bus       (bus_lz)
  );

  ssd_score_ctrl #(.REFRESH_BITS(4), .BLANK_LZ(0)) dut_nz (
    .board_clk (board_clk),
    .Reset     (Reset),
    .bus       (bus_nz)
  );

  always #5 board_clk = ~board_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_scan(input string tag, input logic [31:0] exp_lz, input logic [31:0] exp_nz);
    logic [7:0] want_an;
    int n;
    @(negedge board_clk);
    for (int k = 0; k < 4; k++) begin
      want_an    = 8'hFF;
      want_an[k] = 1'b0;
      n = 0;
      while (bus_lz.an !== want_an && n < 24) begin
        @(negedge board_clk);
        n++;
      end
      check($sformatf("%s an_lz%0d", tag, k), 32'(bus_lz.an), 32'(want_an));
      check($sformatf("%s seg_lz%0d", tag, k), 32'(bus_lz.seg), 32'(exp_lz[k*8 +: 8]));
      check($sformatf("%s an_nz%0d", tag, k), 32'(bus_nz.an), 32'(want_an));
      check($sformatf("%s seg_nz%0d", tag, k), 32'(bus_nz.seg), 32'(exp_nz[k*8 +: 8]));
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus_lz.score_ready !== 1'b1 && n < 40) begin
      @(negedge board_clk);
      n++;
    end
  endtask

  task automatic send(input logic [15:0] v);
    int n;
    int low;
    wait_ready();
    score_in    = v;
    score_valid = 1'b1;
    @(negedge board_clk);
    score_valid = 1'b0;
    low = 0;
    n   = 0;
    while (bus_lz.score_ready !== 1'b1 && n < 40) begin
      low++;
      @(negedge board_clk);
      n++;
    end
    check($sformatf("busy cycles for %0d", v), 32'(low), 32'd17);
  endtask

  initial begin
    vecs[0] = '{16'd1234,  {S1, S2, S3, S4}, {S1, S2, S3, S4}};
    vecs[1] = '{16'd40000, {S9, S9, S9, S9}, {S9, S9, S9, S9}};
    vecs[2] = '{16'd1005,  {S1, S0, S0, S5}, {S1, S0, S0, S5}};
    vecs[3] = '{16'd5,     {BL, BL, BL, S5}, {S0, S0, S0, S5}};
    vecs[4] = '{16'd0,     {BL, BL, BL, S0}, {S0, S0, S0, S0}};
    vecs[5] = '{16'd50,    {BL, BL, S5, S0}, {S0, S0, S5, S0}};
    vecs[6] = '{16'd100,   {BL, S1, S0, S0}, {S0, S1, S0, S0}};
    vecs[7] = '{16'd10000, {S9, S9, S9, S9}, {S9, S9, S9, S9}};
    vecs[8] = '{16'd9999,  {S9, S9, S9, S9}, {S9, S9, S9, S9}};

    // Reset state
    repeat (3) @(negedge board_clk);
    check("reset an", 32'(bus_lz.an), 32'hFF);
    check("reset seg", 32'(bus_lz.seg), 32'hFF);
    check("reset ready", 32'(bus_lz.score_ready), 32'd1);
    Reset  = 1'b0;
    enable = 1'b1;
    check_scan("post-reset", {BL, BL, BL, S0}, {S0, S0, S0, S0});

    foreach (vecs[i]) begin
      send(vecs[i].score);
      check_scan($sformatf("score %0d", vecs[i].score), vecs[i].lz, vecs[i].nz);
    end

    // Reset mid-conversion aborts and clears the display value
    score_in    = 16'd1234;
    score_valid = 1'b1;
    @(negedge board_clk);
    score_valid = 1'b0;
    repeat (5) @(negedge board_clk);
    check("busy before reset", 32'(bus_lz.score_ready), 32'd0);
    Reset = 1'b1;
    #1;
    check("midreset an", 32'(bus_lz.an), 32'hFF);
    check("midreset seg", 32'(bus_lz.seg), 32'hFF);
    check("midreset ready", 32'(bus_lz.score_ready), 32'd1);
    check("midreset seg_nz", 32'(bus_nz.seg), 32'hFF);
    @(negedge board_clk);
    Reset = 1'b0;
    check_scan("after midreset", {BL, BL, BL, S0}, {S0, S0, S0, S0});

    // Busy drop: 77 pulsed at T+5 must be ignored
    wait_ready();
    score_in    = 16'd42;
    score_valid = 1'b1;
    @(negedge board_clk);
    score_valid = 1'b0;
    repeat (4) @(negedge board_clk);
    score_in    = 16'd77;
    score_valid = 1'b1;
    @(negedge board_clk);
    score_valid = 1'b0;
    check("ready during drop", 32'(bus_lz.score_ready), 32'd0);
    wait_ready();
    check_scan("score 42", {BL, BL, S4, S2}, {S0, S0, S4, S2});

    // Valid held high: second accept lands exactly at T+18
    score_in    = 16'd77;
    score_valid = 1'b1;
    @(negedge board_clk);
    check("held ready T+1", 32'(bus_lz.score_ready), 32'd0);
    repeat (16) @(negedge board_clk);
    check("held ready T+17", 32'(bus_lz.score_ready), 32'd0);
    @(negedge board_clk);
    check("held ready T+18", 32'(bus_lz.score_ready), 32'd1);
    @(negedge board_clk);
    score_valid = 1'b0;
    check("reaccept at T+18", 32'(bus_lz.score_ready), 32'd0);
    wait_ready();
    check_scan("score 77", {BL, BL, S7, S7}, {S0, S0, S7, S7});

    // Enable gating
    enable = 1'b0;
    @(negedge board_clk);
    check("disabled an", 32'(bus_lz.an), 32'hFF);
    check("disabled seg", 32'(bus_lz.seg), 32'hFF);
    check("disabled an_nz", 32'(bus_nz.an), 32'hFF);
    repeat (5) @(negedge board_clk);
    check("still disabled an", 32'(bus_lz.an), 32'hFF);
    enable = 1'b1;
    check_scan("re-enabled 77", {BL, BL, S7, S7}, {S0, S0, S7, S7});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
